// File: rtl/mux2x1_rr.sv
// Two-lane to one-lane round-robin merger: each lane is buffered in its own FIFO and
// the buffered words are interleaved onto one registered, lane-tagged output stream.
module mux2x1_rr #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] Entrada0,
   input  logic             validEntrada0,
   input  logic [WIDTH-1:0] Entrada1,
   input  logic             validEntrada1,
   input  logic             pauseSalida,
   output logic [WIDTH-1:0] Salida,
   output logic             validSalida,
   output logic             selectorSalida,
   output logic             fullEntrada0,
   output logic             fullEntrada1,
   output logic             errorEntrada0,
   output logic             errorEntrada1
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [1:0][DEPTH-1:0][WIDTH-1:0] mem_r;
   logic [1:0][AW-1:0]               wptr_r;
   logic [1:0][AW-1:0]               rptr_r;
   logic [1:0][CW-1:0]               count_r;
   logic [1:0]                       err_r;
   logic                             last_r;

   logic [1:0][WIDTH-1:0] din_s;
   logic [1:0]            vin_s;
   logic [1:0]            full_s;
   logic [1:0]            elig_s;
   logic [1:0]            wr_s;
   logic [1:0]            rd_s;
   logic                  grant_s;
   logic                  glane_s;

   assign din_s  = {Entrada1, Entrada0};
   assign vin_s  = {validEntrada1, validEntrada0};
   assign full_s = {(count_r[1] == FULL_CNT), (count_r[0] == FULL_CNT)};
   assign elig_s = {(count_r[1] != {CW{1'b0}}), (count_r[0] != {CW{1'b0}})};
   assign wr_s   = vin_s & ~full_s;
   assign rd_s   = {grant_s & glane_s, grant_s & ~glane_s};

   assign fullEntrada0  = full_s[0];
   assign fullEntrada1  = full_s[1];
   assign errorEntrada0 = err_r[0];
   assign errorEntrada1 = err_r[1];

   // Round-robin grant on pre-edge occupancy; ties go to the lane not granted last.
   always_comb begin
      grant_s = 1'b0;
      glane_s = last_r;
      if (pauseSalida) begin
         grant_s = 1'b0;
         glane_s = last_r;
      end else begin
         case (elig_s)
            2'b11: begin
               grant_s = 1'b1;
               glane_s = ~last_r;
            end
            2'b01: begin
               grant_s = 1'b1;
               glane_s = 1'b0;
            end
            2'b10: begin
               grant_s = 1'b1;
               glane_s = 1'b1;
            end
            default: begin
               grant_s = 1'b0;
               glane_s = last_r;
            end
         endcase
      end
   end

   // Per-lane FIFO storage, pointers, occupancy and sticky overflow flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_r   <= '0;
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
         err_r   <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (wr_s[i]) begin
               mem_r[i][wptr_r[i]] <= din_s[i];
               wptr_r[i]           <= wptr_r[i] + AW'(1);
            end
            if (rd_s[i]) begin
               rptr_r[i] <= rptr_r[i] + AW'(1);
            end
            // Overflow is judged on the pre-edge count, so a same-edge pop does not rescue the word.
            if (vin_s[i] && full_s[i]) begin
               err_r[i] <= 1'b1;
            end
            case ({wr_s[i], rd_s[i]})
               2'b10:   count_r[i] <= count_r[i] + CW'(1);
               2'b01:   count_r[i] <= count_r[i] - CW'(1);
               default: count_r[i] <= count_r[i];
            endcase
         end
      end
   end

   // Registered output stage and last-granted lane tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Salida         <= {WIDTH{1'b0}};
         validSalida    <= 1'b0;
         selectorSalida <= 1'b0;
         last_r         <= 1'b1;
      end else if (grant_s) begin
         Salida         <= mem_r[glane_s][rptr_r[glane_s]];
         validSalida    <= 1'b1;
         selectorSalida <= glane_s;
         last_r         <= glane_s;
      end else begin
         validSalida    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux2x1_rr.sv
// Directed-vector bench for mux2x1_rr with hand-computed expectations.
module tb_mux2x1_rr;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] Entrada0, Entrada1;
   logic       validEntrada0, validEntrada1, pauseSalida;
   logic [7:0] Salida;
   logic       validSalida, selectorSalida;
   logic       fullEntrada0, fullEntrada1, errorEntrada0, errorEntrada1;

   int n_checks = 0;
   int n_fail   = 0;

   mux2x1_rr #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .Entrada0(Entrada0), .validEntrada0(validEntrada0),
      .Entrada1(Entrada1), .validEntrada1(validEntrada1),
      .pauseSalida(pauseSalida),
      .Salida(Salida), .validSalida(validSalida), .selectorSalida(selectorSalida),
      .fullEntrada0(fullEntrada0), .fullEntrada1(fullEntrada1),
      .errorEntrada0(errorEntrada0), .errorEntrada1(errorEntrada1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_out(input string tag, input logic [7:0] d, input logic s);
      check({tag, ".valid"}, 32'(validSalida), 32'd1);
      check({tag, ".data"}, 32'(Salida), 32'(d));
      check({tag, ".sel"}, 32'(selectorSalida), 32'(s));
   endtask

   initial begin
      reset = 1'b0;
      Entrada0 = 8'h00; Entrada1 = 8'h00;
      validEntrada0 = 1'b0; validEntrada1 = 1'b0; pauseSalida = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("rst0.valid", 32'(validSalida), 32'd0);
      check("rst0.data", 32'(Salida), 32'd0);
      check("rst0.full", 32'({fullEntrada1, fullEntrada0}), 32'd0);
      check("rst0.err", 32'({errorEntrada1, errorEntrada0}), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Single lane back-to-back: each word one cycle after its write.
      for (int i = 1; i <= 4; i++) begin
         Entrada0 = 8'(i); validEntrada0 = 1'b1;
         tick();
         if (i > 1) expect_out("single", 8'(i - 1), 1'b0);
      end
      validEntrada0 = 1'b0;
      tick();
      expect_out("single4", 8'h04, 1'b0);
      tick();
      check("single.idle", 32'(validSalida), 32'd0);

      // Overflow while paused.
      pauseSalida = 1'b1;
      for (int i = 0; i < 5; i++) begin
         Entrada0 = 8'h30 + 8'(i); validEntrada0 = 1'b1;
         tick();
         if (i == 3) begin
            check("ovf.full", 32'(fullEntrada0), 32'd1);
            check("ovf.err_pre", 32'(errorEntrada0), 32'd0);
         end
      end
      check("ovf.err", 32'(errorEntrada0), 32'd1);
      check("ovf.paused", 32'(validSalida), 32'd0);
      validEntrada0 = 1'b0;
      tick();
      check("ovf.sticky", 32'(errorEntrada0), 32'd1);
      check("ovf.err1", 32'(errorEntrada1), 32'd0);

      // Full lane with simultaneous pop: 0x55 must be dropped.
      pauseSalida = 1'b0; Entrada0 = 8'h55; validEntrada0 = 1'b1;
      tick();
      validEntrada0 = 1'b0;
      expect_out("pop30", 8'h30, 1'b0);
      check("pop.full", 32'(fullEntrada0), 32'd0);
      check("pop.err", 32'(errorEntrada0), 32'd1);
      for (int i = 1; i < 4; i++) begin
         tick();
         expect_out("drain", 8'h30 + 8'(i), 1'b0);
      end
      tick();
      check("drain.idle", 32'(validSalida), 32'd0);

      // Reset mid-operation with lane-1 word on output and lane 0 buffered.
      Entrada1 = 8'h5A; validEntrada1 = 1'b1;
      tick();
      validEntrada1 = 1'b0; Entrada0 = 8'h77; validEntrada0 = 1'b1;
      tick();
      validEntrada0 = 1'b0;
      expect_out("pre_rst", 8'h5A, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("rst1.valid", 32'(validSalida), 32'd0);
      check("rst1.data", 32'(Salida), 32'd0);
      check("rst1.sel", 32'(selectorSalida), 32'd0);
      check("rst1.err", 32'({errorEntrada1, errorEntrada0}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check("rst1.discard", 32'(validSalida), 32'd0);
      Entrada1 = 8'hA5; validEntrada1 = 1'b1;
      tick();
      validEntrada1 = 1'b0;
      check("a5.noBypass", 32'(validSalida), 32'd0);
      tick();
      expect_out("a5", 8'hA5, 1'b1);
      tick();
      check("a5.idle", 32'(validSalida), 32'd0);

      // Interleave after paused prefill (last = 1 so lane 0 first).
      pauseSalida = 1'b1;
      Entrada0 = 8'h10; Entrada1 = 8'h20; validEntrada0 = 1'b1; validEntrada1 = 1'b1;
      tick();
      Entrada0 = 8'h11; Entrada1 = 8'h21;
      tick();
      validEntrada0 = 1'b0; validEntrada1 = 1'b0; pauseSalida = 1'b0;
      tick(); expect_out("il0", 8'h10, 1'b0);
      tick(); expect_out("il1", 8'h20, 1'b1);
      tick(); expect_out("il2", 8'h11, 1'b0);
      tick(); expect_out("il3", 8'h21, 1'b1);
      tick(); check("il.idle", 32'(validSalida), 32'd0);

      // Pause mid-stream.
      pauseSalida = 1'b1;
      Entrada0 = 8'h40; Entrada1 = 8'h50; validEntrada0 = 1'b1; validEntrada1 = 1'b1;
      tick();
      Entrada0 = 8'h41; Entrada1 = 8'h51;
      tick();
      validEntrada0 = 1'b0; validEntrada1 = 1'b0; pauseSalida = 1'b0;
      tick(); expect_out("pm0", 8'h40, 1'b0);
      tick(); expect_out("pm1", 8'h50, 1'b1);
      pauseSalida = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("pm.paused", 32'(validSalida), 32'd0);
         check("pm.hold", 32'(Salida), 32'h50);
         check("pm.holdsel", 32'(selectorSalida), 32'd1);
      end
      pauseSalida = 1'b0;
      tick(); expect_out("pm2", 8'h41, 1'b0);
      tick(); expect_out("pm3", 8'h51, 1'b1);
      tick(); check("pm.idle", 32'(validSalida), 32'd0);

      // Lane 1 overflow.
      pauseSalida = 1'b1;
      for (int i = 0; i < 5; i++) begin
         Entrada1 = 8'h60 + 8'(i); validEntrada1 = 1'b1;
         tick();
      end
      validEntrada1 = 1'b0;
      check("ovf1.full", 32'(fullEntrada1), 32'd1);
      check("ovf1.err", 32'(errorEntrada1), 32'd1);
      check("ovf1.lane0", 32'(fullEntrada0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux2x1_rr.md
# mux2x1_rr

Two-lane to one-lane round-robin multiplexer: the merging counterpart of the 1:2 demultiplexer. It accepts two independent WIDTH-bit valid-qualified input streams and buffers each in its own FIFO. It then interleaves the buffered words onto a single registered output stream, tagging each word with its source lane so the downstream demultiplexer can steer it back. Per-lane full flags provide backpressure, and sticky error flags record dropped writes.

## Interface
- WIDTH, 8, data width of every lane.
- DEPTH, 4, words per lane FIFO; power of two, ≥ 2.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- Entrada0  input  WIDTH  lane 0 data.
- validEntrada0  input  1  lane 0 write strobe.
- Entrada1  input  WIDTH  lane 1 data.
- validEntrada1  input  1  lane 1 write strobe.
- pauseSalida  input  1  when 1, no word is issued this cycle.
- Salida  output  WIDTH  registered output data.
- validSalida  output  1  registered; 1 for exactly the cycles Salida carries a new word.
- selectorSalida  output  1  registered; source lane of the current Salida word.
- fullEntrada0  output  1  combinational; lane 0 FIFO holds DEPTH words.
- fullEntrada1  output  1  combinational; lane 1 FIFO holds DEPTH words.
- errorEntrada0  output  1  registered, sticky; lane 0 write attempted while full.
- errorEntrada1  output  1  registered, sticky; lane 1 write attempted while full.

## Operation
- **Per-lane FIFO.** Each lane has a write pointer, a read pointer and an occupancy count (0..DEPTH, width $clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- **Write.** validEntradaN=1 and fullEntradaN=0 stores EntradaN and increments the write pointer.
- **Full-lane write.** validEntradaN=1 with fullEntradaN=1 drops the word, sets errorEntradaN, and leaves the FIFO unchanged. "Full" is judged on the count before the edge, even if a read from that lane occurs on the same edge.
- **Eligibility.** Lane N is eligible when countN ≠ 0 (pre-edge). There is no write-to-read bypass: a word written into an empty FIFO is not eligible until the next cycle.
- **Arbiter state.** The arbiter keeps a 1-bit register `last` (last lane granted); reset value 1, so lane 0 wins first.
- **Grant.** Granting happens only when pauseSalida=0:
  - both lanes eligible → grant lane ~last;
  - only one lane eligible → grant that lane;
  - no lane eligible → no grant.
- **On grant to lane N:**
  - Salida ← head of lane N;
  - selectorSalida ← N;
  - validSalida ← 1;
  - the lane N read pointer increments;
  - last ← N.
- **No grant** (paused or both empty): validSalida ← 0. Salida, selectorSalida and last hold their values.
- **Same-edge read and write.** A read and a write on the same lane in the same edge leave the count unchanged (net 0).
- **Error flags.** errorEntradaN clears only on reset.

## Timing
- **Reset values** (asynchronous; every output value below takes effect without waiting for a clock edge):
  - Salida = 0, validSalida = 0, selectorSalida = 0;
  - errorEntrada0/1 = 0;
  - all pointers and counts = 0, so fullEntrada0/1 = 0;
  - last = 1.
- **Reset mid-operation.** Buffered words are discarded. First eligibility returns one cycle after the first post-reset write.
- **Latency.** A word written at edge k appears on Salida at edge k+1 at the earliest; that is one cycle when the output is idle and unpaused.
- **Throughput.** One output word per cycle total. With both lanes continuously non-empty, the output alternates 0,1,0,1…
- **Pause.** pauseSalida is sampled at the edge; the pause takes effect that edge (validSalida is 0 in the following cycle). Inputs continue to be accepted while paused.
- **Full flag.** fullEntradaN deasserts in the cycle after the edge that pops lane N.

## Test plan
- **Reset.** Assert reset mid-cycle → all outputs 0 immediately without a clock edge; after release, write 0xA5 on lane 1 → next edge Salida=0xA5, selectorSalida=1, validSalida=1; following edge validSalida=0.
- **Interleave.** Pre-fill lane 0 with 0x10,0x11 and lane 1 with 0x20,0x21 while paused, then release → Salida sequence 0x10,0x20,0x11,0x21 on consecutive edges, selector 0,1,0,1, then validSalida=0.
- **Single lane.** Write 0x01..0x04 back-to-back on lane 0 only → outputs 0x01..0x04 each one cycle after its write, selector always 0, no gaps.
- **Overflow.** With pause held, write DEPTH+1 words (0x30..0x34) to lane 0 → fullEntrada0=1 after the 4th write, 0x34 dropped, errorEntrada0=1 and sticky. After unpause, exactly 0x30..0x33 are emitted.
- **Full with simultaneous pop.** Lane 0 full, pause deasserted and a write of 0x55 on the same edge → 0x55 is rejected, errorEntrada0=1, count goes DEPTH−1; fullEntrada0 drops next cycle.
- **Pause mid-stream.** Both lanes loaded, assert pauseSalida for 3 cycles → validSalida=0 for 3 cycles, Salida holds its last value, and round-robin resumes with the lane opposite the last grant.
